// File: rtl/cop_issue_queue_if.sv
// Host-side and core-side signal bundle for the coprocessor issue queue.
// master = host/core environment, slave = the issue queue itself.
interface cop_issue_queue_if #(
  parameter int unsigned AW = 3
) ();
  logic [31:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic        enable;
  logic [31:0] cop_instr;
  logic        cop_activate;
  logic        cop_done;
  logic [15:0] cop_data;
  logic [15:0] res_data;
  logic        res_valid;
  logic        res_ack;
  logic        busy;
  logic [AW:0] fifo_count;
  logic        timeout_err;
  logic        err_clear;

  modport master (
    output in_instr, in_valid, enable, cop_done, cop_data, res_ack, err_clear,
    input  in_ready, cop_instr, cop_activate, res_data, res_valid, busy, fifo_count, timeout_err
  );

  modport slave (
    input  in_instr, in_valid, enable, cop_done, cop_data, res_ack, err_clear,
    output in_ready, cop_instr, cop_activate, res_data, res_valid, busy, fifo_count, timeout_err
  );
endinterface

// File: rtl/cop_issue_queue.sv
// Instruction FIFO plus single-outstanding issue sequencer for the matrix coprocessor,
// with READ result capture and a completion watchdog.
module cop_issue_queue #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned AW      = 3,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned CW      = 16,
  parameter logic [3:0]  OP_READ = 4'b0001
) (
  input logic              clk,
  input logic              reset_n,
  cop_issue_queue_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e        state_q, state_d;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic [CW-1:0] wd_q, wd_d;
  logic [31:0]   cop_instr_q, cop_instr_d;
  logic [15:0]   res_data_q, res_data_d;
  logic          res_valid_q, res_valid_d;
  logic          err_q, err_d;

  logic        full, push, pop, issue_ok, in_wait, wd_hit, done_evt, timeout_evt, capture;
  logic [31:0] head;

  // No full-bypass: a pop in the same cycle does not open the FIFO.
  assign full        = (count_q == (AW+1)'(DEPTH));
  assign push        = bus.in_valid & ~full;
  assign pop         = (state_q == StIssue);
  assign head        = mem_q[rptr_q];
  // A READ waits until the previous result has been consumed.
  assign issue_ok    = bus.enable & (count_q != '0) & ~((head[3:0] == OP_READ) & res_valid_q);
  assign in_wait     = (state_q == StWait);
  assign wd_hit      = (wd_q == CW'(TIMEOUT - 1));
  assign done_evt    = in_wait & bus.cop_done;
  assign timeout_evt = in_wait & ~bus.cop_done & wd_hit;
  assign capture     = done_evt & (cop_instr_q[3:0] == OP_READ);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (issue_ok) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (bus.cop_done || wd_hit) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.cop_activate = (state_q == StIssue);
    bus.busy         = (state_q != StIdle);
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    cop_instr_d = ((state_q == StIdle) && issue_ok) ? head : cop_instr_q;

    wd_d = '0;
    if (in_wait && !bus.cop_done && !wd_hit) wd_d = wd_q + CW'(1);

    // Capture beats a coincident acknowledge.
    res_data_d  = capture ? bus.cop_data : res_data_q;
    res_valid_d = res_valid_q;
    if (capture) begin
      res_valid_d = 1'b1;
    end else if (bus.res_ack) begin
      res_valid_d = 1'b0;
    end

    err_d = timeout_evt | (err_q & ~bus.err_clear);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.in_instr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      wd_q        <= '0;
      cop_instr_q <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      wd_q        <= wd_d;
      cop_instr_q <= cop_instr_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready    = ~full;
  assign bus.cop_instr   = cop_instr_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.fifo_count  = count_q;
  assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_cop_issue_queue.sv
// Randomized and directed bench for cop_issue_queue: a queue-based reference model predicts
// every output each cycle, and scoreboards track issue order and captured READ results.
module tb_cop_issue_queue;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned AW      = 3;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CW      = 16;
  localparam logic [3:0]  OP_READ = 4'h1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cop_issue_queue_if #(.AW(AW)) bus ();

  cop_issue_queue #(
    .DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT), .CW(CW), .OP_READ(OP_READ)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_issue[$];
  logic [15:0] exp_res[$];

  // Reference model: phase 0 idle, 1 issuing, 2 waiting for the core.
  logic [31:0] m_q[$];
  int          m_phase;
  int          m_wd;
  logic        m_resv;
  logic [15:0] m_resd;
  logic        m_err;
  logic [31:0] m_instr;

  int p_valid, p_en, p_done, p_ack, p_clr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    exp_issue.delete();
    exp_res.delete();
    m_phase = 0;
    m_wd    = 0;
    m_resv  = 1'b0;
    m_resd  = '0;
    m_err   = 1'b0;
    m_instr = '0;
  endfunction

  function automatic void model_step();
    logic        push, cap, fire;
    logic [31:0] hd;
    push = bus.in_valid && (m_q.size() < DEPTH);
    cap  = 1'b0;
    fire = 1'b0;
    case (m_phase)
      0: begin
        if (m_q.size() > 0) begin
          hd = m_q[0];
          if (bus.enable && !((hd[3:0] == OP_READ) && m_resv)) begin
            m_instr = hd;
            m_phase = 1;
          end
        end
      end
      1: begin
        void'(m_q.pop_front());
        m_phase = 2;
        m_wd    = 0;
      end
      default: begin
        if (bus.cop_done) begin
          cap     = (m_instr[3:0] == OP_READ);
          m_phase = 0;
          m_wd    = 0;
        end else if (m_wd == TIMEOUT - 1) begin
          fire    = 1'b1;
          m_phase = 0;
          m_wd    = 0;
        end else begin
          m_wd++;
        end
      end
    endcase
    if (push) begin
      m_q.push_back(bus.in_instr);
      exp_issue.push_back(bus.in_instr);
    end
    if (cap) begin
      m_resv = 1'b1;
      m_resd = bus.cop_data;
      exp_res.push_back(bus.cop_data);
    end else if (bus.res_ack) begin
      m_resv = 1'b0;
    end
    if (fire) m_err = 1'b1;
    else if (bus.err_clear) m_err = 1'b0;
  endfunction

  // One clock of explicit stimulus; the model advances on the same edge as the DUT.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic en, input logic dn,
                     input logic [15:0] dat, input logic ack, input logic clr);
    @(negedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.enable    = en;
    bus.cop_done  = dn;
    bus.cop_data  = dat;
    bus.res_ack   = ack;
    bus.err_clear = clr;
    @(posedge clk);
    if (reset_n) model_step();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 32'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic rnd(input int n);
    logic [31:0] w;
    repeat (n) begin
      w      = $urandom();
      w[3:0] = 4'($urandom_range(0, 3));
      cyc($urandom_range(0, 99) < p_valid, w, $urandom_range(0, 99) < p_en,
          $urandom_range(0, 99) < p_done, 16'($urandom()),
          $urandom_range(0, 99) < p_ack, $urandom_range(0, 99) < p_clr);
    end
  endtask

  // Monitor: per-cycle model comparison plus issue-order and result scoreboards.
  initial begin : monitor
    logic prev_rv;
    prev_rv = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.cop_activate) begin
        if (exp_issue.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL issue_order: got 0x%0h, expected no issue", bus.cop_instr);
        end else begin
          check("issue_order", bus.cop_instr, exp_issue.pop_front());
        end
      end
      if (bus.res_valid && !prev_rv) begin
        if (exp_res.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL result: got 0x%0h, expected no result", bus.res_data);
        end else begin
          check("result", {16'h0, bus.res_data}, {16'h0, exp_res.pop_front()});
        end
      end
      prev_rv = bus.res_valid;
      check("in_ready", 32'(bus.in_ready), 32'(m_q.size() < DEPTH));
      check("fifo_count", 32'(bus.fifo_count), 32'(m_q.size()));
      check("busy", 32'(bus.busy), 32'(m_phase != 0));
      check("cop_activate", 32'(bus.cop_activate), 32'(m_phase == 1));
      check("cop_instr", bus.cop_instr, m_instr);
      check("res_valid", 32'(bus.res_valid), 32'(m_resv));
      check("res_data", {16'h0, bus.res_data}, {16'h0, m_resd});
      check("timeout_err", 32'(bus.timeout_err), 32'(m_err));
    end
  end

  initial begin : stim
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.enable    = 1'b0;
    bus.cop_done  = 1'b0;
    bus.cop_data  = '0;
    bus.res_ack   = 1'b0;
    bus.err_clear = 1'b0;
    model_reset();
    #3;
    check("rst_fifo_count", 32'(bus.fifo_count), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);
    check("rst_busy", 32'(bus.busy), 32'h0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;

    // Single WRITE, completion 5 cycles after activation.
    cyc(1'b1, 32'h0000_1232, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    #1 check("write_count_1", 32'(bus.fifo_count), 32'h1);
    idle(1);
    #1 check("write_activate", 32'(bus.cop_activate), 32'h1);
    check("write_instr", bus.cop_instr, 32'h0000_1232);
    idle(4);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 16'h5555, 1'b0, 1'b0);
    idle(2);
    #1 check("write_done_busy", 32'(bus.busy), 32'h0);
    check("write_no_result", 32'(bus.res_valid), 32'h0);
    check("write_count_0", 32'(bus.fifo_count), 32'h0);

    // Fill past capacity with issue frozen, then drain across the pointer wrap.
    for (int i = 0; i < 9; i++) cyc(1'b1, 32'h100 + 32'(i * 16) + 32'h2, 1'b0, 1'b0, 16'h0,
                                     1'b0, 1'b0);
    #1 check("full_count", 32'(bus.fifo_count), 32'h8);
    check("full_ready", 32'(bus.in_ready), 32'h0);
    repeat (3) cyc(1'b1, 32'h100 + 32'(8 * 16) + 32'h2, 1'b1, 1'b1, 16'h0, 1'b0, 1'b0);
    repeat (40) cyc(1'b0, 32'h0, 1'b1, 1'b1, 16'h0, 1'b0, 1'b0);
    #1 check("wrap_drained", 32'(bus.fifo_count), 32'h0);

    // READ capture, and a second READ held back until acknowledge.
    cyc(1'b1, 32'h0000_0051, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    idle(2);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    #1 check("read_data", {16'h0, bus.res_data}, 32'h0000_BEEF);
    check("read_valid", 32'(bus.res_valid), 32'h1);
    cyc(1'b1, 32'h0000_0061, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    idle(4);
    #1 check("read_held", 32'(bus.busy), 32'h0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    #1 check("ack_clears", 32'(bus.res_valid), 32'h0);
    idle(1);
    #1 check("read2_issue", bus.cop_instr, 32'h0000_0061);
    idle(1);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    idle(2);

    // Watchdog expiry, then clear.
    cyc(1'b1, 32'h0000_0002, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    idle(17);
    #1 check("wd_not_yet", 32'(bus.timeout_err), 32'h0);
    idle(1);
    #1 check("wd_fire", 32'(bus.timeout_err), 32'h1);
    check("wd_idle", 32'(bus.busy), 32'h0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    #1 check("err_cleared", 32'(bus.timeout_err), 32'h0);

    // Completion on the expiry cycle wins.
    cyc(1'b1, 32'h0000_0003, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    idle(17);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 16'h0, 1'b0, 1'b0);
    #1 check("done_beats_wd", 32'(bus.timeout_err), 32'h0);

    // Expiry coincident with err_clear keeps the error.
    cyc(1'b1, 32'h0000_0002, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    idle(17);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    #1 check("fire_beats_clear", 32'(bus.timeout_err), 32'h1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1);

    // Asynchronous reset while waiting with three entries queued.
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h200 + 32'(i * 16) + 32'h2, 1'b1, 1'b0, 16'h0,
                                     1'b0, 1'b0);
    idle(2);
    #2 reset_n = 1'b0;
    model_reset();
    #1 check("arst_count", 32'(bus.fifo_count), 32'h0);
    check("arst_busy", 32'(bus.busy), 32'h0);
    check("arst_instr", bus.cop_instr, 32'h0);
    check("arst_ready", 32'(bus.in_ready), 32'h1);
    idle(2);
    #3 reset_n = 1'b1;
    idle(6);
    #1 check("post_rst_quiet", 32'(bus.busy), 32'h0);

    // Randomized segments with varied traffic mixes.
    for (int s = 0; s < 6; s++) begin
      p_valid = $urandom_range(20, 95);
      p_en    = $urandom_range(50, 100);
      p_done  = (s % 3 == 0) ? 5 : ((s % 3 == 1) ? 20 : 60);
      p_ack   = $urandom_range(10, 90);
      p_clr   = $urandom_range(0, 20);
      rnd(400);
    end

    p_valid = 0; p_en = 100; p_done = 100; p_ack = 100; p_clr = 0;
    rnd(100);
    #1 check("drain_scoreboard", 32'(exp_issue.size()), 32'h0);
    check("drain_count", 32'(bus.fifo_count), 32'h0);

    @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
